// File: rtl/zipwb_memslave.sv
// rtl/zipwb_memslave.sv - pipelined Wishbone RAM responder, fixed latency, bounded outstanding requests
// Optional ZIPWB_MEMSLAVE_ADDR_ERR_EN: out-of-range addresses return o_wb_err instead of aliasing.
module zipwb_memslave #(
  parameter int AW      = 30,
  parameter int LGMEMSZ = 12,
  parameter int LATENCY = 2,
  parameter int MAXPEND = 2
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  input  logic          i_wb_we,
  input  logic [AW-1:0] i_wb_addr,
  input  logic [31:0]   i_wb_data,
  input  logic [3:0]    i_wb_sel,
  output logic          o_wb_stall,
  output logic          o_wb_ack,
  output logic [31:0]   o_wb_data,
  output logic          o_wb_err
);
  localparam int CW   = $clog2(MAXPEND + 1);
  localparam int LAST = LATENCY - 1;

  logic [31:0]        mem [0:(1<<LGMEMSZ)-1];
  logic [LATENCY-1:0] vld_q, vld_d, err_q, err_d;
  logic [31:0]        dat_q [LATENCY];
  logic [31:0]        dat_d [LATENCY];
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [LGMEMSZ-1:0] idx;
  logic               addr_bad, retire, accept, wr_en;

  assign idx = i_wb_addr[LGMEMSZ-1:0];

`ifdef ZIPWB_MEMSLAVE_ADDR_ERR_EN
  generate
    if (LGMEMSZ < AW) begin : g_hi
      assign addr_bad = |i_wb_addr[AW-1:LGMEMSZ];
    end else begin : g_nohi
      assign addr_bad = 1'b0;
    end
  endgenerate
`else
  assign addr_bad = 1'b0;
  // Upper address bits alias onto the RAM in this build.
  generate
    if (LGMEMSZ < AW) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^i_wb_addr[AW-1:LGMEMSZ];
    end
  endgenerate
`endif

  // A retiring request frees its slot in the same cycle, so stall only when full and nothing leaves.
  assign retire     = vld_q[LAST] & i_wb_cyc;
  assign o_wb_stall = (cnt_q == CW'(MAXPEND)) & ~retire;
  assign accept     = i_wb_cyc & i_wb_stb & ~o_wb_stall;
  assign wr_en      = accept & i_wb_we & ~addr_bad;

  always_comb begin
    vld_d = '0;
    err_d = '0;
    for (int i = 0; i < LATENCY; i++) dat_d[i] = '0;
    if (i_wb_cyc) begin
      vld_d[0] = accept;
      err_d[0] = accept & addr_bad;
      dat_d[0] = (accept & ~i_wb_we & ~addr_bad) ? mem[idx] : 32'h0;
      for (int i = 1; i < LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
        err_d[i] = err_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!i_wb_cyc)
      cnt_d = '0;
    else if (accept & ~retire)
      cnt_d = cnt_q + CW'(1);
    else if (~accept & retire)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      vld_q <= '0;
      err_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < LATENCY; i++) dat_q[i] <= dat_d[i];
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++)
        if (i_wb_sel[b]) mem[idx][8*b +: 8] <= i_wb_data[8*b +: 8];
    end
  end

  assign o_wb_ack  = retire & ~err_q[LAST];
  assign o_wb_err  = retire & err_q[LAST];
  assign o_wb_data = (retire & ~err_q[LAST]) ? dat_q[LAST] : 32'h0;

endmodule

// File: tb/tb_zipwb_memslave.sv
// tb/tb_zipwb_memslave.sv - randomized and directed bench for zipwb_memslave against a request-queue model
module tb_zipwb_memslave;
  localparam int LAT = 2;
  localparam int MP  = 2;

  logic        clk = 1'b0;
  logic        rstn, cyc, stb, we;
  logic [29:0] addr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic        stall, ack, err;
  logic [31:0] rdat;

  zipwb_memslave u_dut (
    .i_clk(clk), .i_reset_n(rstn), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdat), .i_wb_sel(sel),
    .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_data(rdat), .o_wb_err(err)
  );

  always #5 clk = ~clk;

  // Model: RAM image plus a queue of outstanding requests, each with the cycle its response is due.
  logic [31:0] ref_mem [0:4095];
  int          q_due [$];
  logic [31:0] q_dat [$];
  bit          q_err [$];
  int          now = 0;
  int          total = 0, bad = 0;
  logic        exp_ack, exp_err, exp_stall, obs_ack, obs_err, obs_stall;
  logic [31:0] exp_data, obs_data;

  task automatic drive(input logic c, input logic s, input logic w, input logic [29:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    cyc = c; stb = s; we = w; addr = a; wdat = d; sel = m;
  endtask

  task automatic step();
    bit ret, hi;
    logic [11:0] ix;
    @(negedge clk);
    obs_ack = ack; obs_err = err; obs_stall = stall; obs_data = rdat;
    ret = (q_due.size() > 0) && (q_due[0] == now) && cyc;
    exp_ack = 1'b0; exp_err = 1'b0; exp_data = 32'h0;
    if (ret) begin
      exp_ack  = !q_err[0];
      exp_err  = q_err[0];
      exp_data = q_err[0] ? 32'h0 : q_dat[0];
    end
    exp_stall = (q_due.size() == MP) && !ret;
    @(posedge clk);
    if (!rstn) begin
      q_due.delete(); q_dat.delete(); q_err.delete();
    end else begin
      if (ret) begin
        void'(q_due.pop_front()); void'(q_dat.pop_front()); void'(q_err.pop_front());
      end
      if (!cyc) begin
        q_due.delete(); q_dat.delete(); q_err.delete();
      end else if (stb && !exp_stall) begin
        ix = addr[11:0];
`ifdef ZIPWB_MEMSLAVE_ADDR_ERR_EN
        hi = |addr[29:12];
`else
        hi = 1'b0;
`endif
        q_due.push_back(now + LAT);
        q_err.push_back(hi);
        if (hi || we) q_dat.push_back(32'h0);
        else q_dat.push_back(ref_mem[ix]);
        if (we && !hi)
          for (int b = 0; b < 4; b++)
            if (sel[b]) ref_mem[ix][8*b +: 8] = wdat[8*b +: 8];
      end
    end
    now++;
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive(0, 0, 0, 30'h0, 32'h0, 4'h0);
    step(); step();
    total++;
    if ({obs_ack, obs_err, obs_stall, obs_data} !== 35'h0) begin
      bad++; $display("FAIL reset_state ack=%b err=%b stall=%b data=%h want all zero", obs_ack, obs_err, obs_stall, obs_data);
    end
    rstn = 1'b1;
    step();
    total++;
    if ({obs_ack, obs_err, obs_stall, obs_data} !== 35'h0) begin
      bad++; $display("FAIL reset_release ack=%b err=%b stall=%b data=%h want all zero", obs_ack, obs_err, obs_stall, obs_data);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 32; i++) begin
      drive(1, 1, 1, 30'(i), $urandom, 4'hf);
      step();
      total++;
      if ({obs_ack, obs_err, obs_stall, obs_data} !== {exp_ack, exp_err, exp_stall, exp_data}) begin
        bad++; $display("FAIL fill i=%0d got ack=%b stall=%b data=%h want ack=%b stall=%b data=%h", i, obs_ack, obs_stall, obs_data, exp_ack, exp_stall, exp_data);
      end
    end
    drive(1, 0, 0, 30'h0, 32'h0, 4'h0);
    repeat (3) step();
  endtask

  task automatic test_write_read();
    int acks = 0;
    for (int c = 0; c < 5; c++) begin
      if (c == 0) drive(1, 1, 1, 30'h010, 32'h12345678, 4'hf);
      else if (c == 1) drive(1, 1, 0, 30'h010, 32'h0, 4'h0);
      else drive(1, 0, 0, 30'h0, 32'h0, 4'h0);
      step();
      total++;
      if ({obs_ack, obs_err, obs_stall, obs_data} !== {exp_ack, exp_err, exp_stall, exp_data}) begin
        bad++; $display("FAIL wr_rd_model c=%0d got ack=%b data=%h want ack=%b data=%h", c, obs_ack, obs_data, exp_ack, exp_data);
      end
      if (obs_ack) acks++;
      if (c == 3) begin
        total++;
        if (obs_ack !== 1'b1 || obs_data !== 32'h12345678) begin
          bad++; $display("FAIL wr_rd_data ack=%b data=%h want ack=1 data=12345678", obs_ack, obs_data);
        end
      end
    end
    total++;
    if (acks != 2) begin bad++; $display("FAIL wr_rd_acks got %0d want 2", acks); end
  endtask

  task automatic test_byte_sel();
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: drive(1, 1, 1, 30'h020, 32'h0, 4'hf);
        1: drive(1, 1, 1, 30'h020, 32'hAABBCCDD, 4'b0101);
        2: drive(1, 1, 0, 30'h020, 32'h0, 4'h0);
        default: drive(1, 0, 0, 30'h0, 32'h0, 4'h0);
      endcase
      step();
      total++;
      if ({obs_ack, obs_err, obs_stall, obs_data} !== {exp_ack, exp_err, exp_stall, exp_data}) begin
        bad++; $display("FAIL bytesel_model c=%0d got ack=%b data=%h want ack=%b data=%h", c, obs_ack, obs_data, exp_ack, exp_data);
      end
      if (c == 4) begin
        total++;
        if (obs_ack !== 1'b1 || obs_data !== 32'h00BB00DD) begin
          bad++; $display("FAIL bytesel_data ack=%b data=%h want ack=1 data=00bb00dd", obs_ack, obs_data);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [29:0] al [4];
    logic [31:0] got [$];
    int k = 0;
    al[0] = 30'h010; al[1] = 30'h020; al[2] = 30'h000; al[3] = 30'h001;
    for (int c = 0; c < 12; c++) begin
      if (k < 4) drive(1, 1, 0, al[k], 32'h0, 4'h0);
      else drive(1, 0, 0, 30'h0, 32'h0, 4'h0);
      step();
      total++;
      if ({obs_ack, obs_err, obs_stall, obs_data} !== {exp_ack, exp_err, exp_stall, exp_data}) begin
        bad++; $display("FAIL b2b_model c=%0d got ack=%b stall=%b data=%h want ack=%b stall=%b data=%h", c, obs_ack, obs_stall, obs_data, exp_ack, exp_stall, exp_data);
      end
      if (obs_ack) got.push_back(obs_data);
      if (stb && !exp_stall) k++;
    end
    total++;
    if (got.size() != 4) begin
      bad++; $display("FAIL b2b_count got %0d acks want 4", got.size());
    end else if (got[0] !== 32'h12345678 || got[1] !== 32'h00BB00DD) begin
      bad++; $display("FAIL b2b_order first=%h second=%h want 12345678 00bb00dd", got[0], got[1]);
    end
  endtask

  task automatic test_cyc_drop();
    int acks = 0;
    for (int c = 0; c < 8; c++) begin
      case (c)
        0: drive(1, 1, 0, 30'h010, 32'h0, 4'h0);
        1: drive(1, 1, 0, 30'h020, 32'h0, 4'h0);
        2: drive(0, 0, 0, 30'h0, 32'h0, 4'h0);
        3: drive(1, 1, 0, 30'h010, 32'h0, 4'h0);
        default: drive(1, 0, 0, 30'h0, 32'h0, 4'h0);
      endcase
      step();
      total++;
      if ({obs_ack, obs_err, obs_stall, obs_data} !== {exp_ack, exp_err, exp_stall, exp_data}) begin
        bad++; $display("FAIL drop_model c=%0d got ack=%b data=%h want ack=%b data=%h", c, obs_ack, obs_data, exp_ack, exp_data);
      end
      if (c >= 2 && obs_ack) begin
        acks++;
        total++;
        if (c != 5 || obs_data !== 32'h12345678) begin
          bad++; $display("FAIL drop_ack at c=%0d data=%h want only c=5 data=12345678", c, obs_data);
        end
      end
    end
    total++;
    if (acks != 1) begin bad++; $display("FAIL drop_acks got %0d want 1", acks); end
  endtask

  task automatic test_alias();
    logic [31:0] want_rd;
    logic        want_err;
`ifdef ZIPWB_MEMSLAVE_ADDR_ERR_EN
    want_rd = 32'h11111111; want_err = 1'b1;
`else
    want_rd = 32'hCAFEF00D; want_err = 1'b0;
`endif
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: drive(1, 1, 1, 30'h0000, 32'h11111111, 4'hf);
        1: drive(1, 1, 1, 30'h1000, 32'hCAFEF00D, 4'hf);
        2: drive(1, 1, 0, 30'h0000, 32'h0, 4'h0);
        default: drive(1, 0, 0, 30'h0, 32'h0, 4'h0);
      endcase
      step();
      total++;
      if ({obs_ack, obs_err, obs_stall, obs_data} !== {exp_ack, exp_err, exp_stall, exp_data}) begin
        bad++; $display("FAIL alias_model c=%0d got ack=%b err=%b data=%h want ack=%b err=%b data=%h", c, obs_ack, obs_err, obs_data, exp_ack, exp_err, exp_data);
      end
      if (c == 3) begin
        total++;
        if (obs_err !== want_err || obs_ack !== !want_err || obs_data !== 32'h0) begin
          bad++; $display("FAIL alias_wr_resp ack=%b err=%b data=%h want err=%b", obs_ack, obs_err, obs_data, want_err);
        end
      end
      if (c == 4) begin
        total++;
        if (obs_ack !== 1'b1 || obs_data !== want_rd) begin
          bad++; $display("FAIL alias_rd ack=%b data=%h want ack=1 data=%h", obs_ack, obs_data, want_rd);
        end
      end
    end
  endtask

  task automatic test_reset_pending();
    int acks = 0;
    drive(1, 1, 0, 30'h010, 32'h0, 4'h0); step();
    drive(1, 1, 0, 30'h020, 32'h0, 4'h0); step();
    drive(1, 0, 0, 30'h0, 32'h0, 4'h0);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      if (c == 0) begin
        total++;
        if (obs_ack !== 1'b0 || obs_err !== 1'b0 || obs_stall !== 1'b0) begin
          bad++; $display("FAIL rstpend_edge ack=%b err=%b stall=%b want 0 0 0", obs_ack, obs_err, obs_stall);
        end
      end
      if (obs_ack || obs_err) acks++;
    end
    total++;
    if (acks != 0) begin bad++; $display("FAIL rstpend_late got %0d responses want 0", acks); end
  endtask

  task automatic test_random();
    logic [29:0] a;
    for (int c = 0; c < 600; c++) begin
      a = 30'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) a[29:12] = 18'($urandom);
      drive($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
            a, $urandom, 4'($urandom));
      step();
      total++;
      if ({obs_ack, obs_err, obs_stall, obs_data} !== {exp_ack, exp_err, exp_stall, exp_data}) begin
        bad++; $display("FAIL random c=%0d got ack=%b err=%b stall=%b data=%h want ack=%b err=%b stall=%b data=%h", c, obs_ack, obs_err, obs_stall, obs_data, exp_ack, exp_err, exp_stall, exp_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_read();
    test_byte_sel();
    test_back_to_back();
    test_cyc_drop();
    test_alias();
    test_reset_pending();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
